// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: redirect input, instruction-memory request/response, and
// the instruction-queue enqueue port.
interface fetch_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic                redirect_valid;
  logic [XLEN-1:0]     redirect_pc;
  logic [XLEN-1:0]     imem_addr;
  logic [3:0]          imem_rmask;
  logic [XLEN-1:0]     imem_rdata;
  logic                imem_resp;
  logic                iq_full;
  logic                iq_enqueue;
  logic [2*XLEN-1:0]   iq_din;

  modport master (
    input  redirect_valid, redirect_pc, imem_rdata, imem_resp, iq_full,
    output imem_addr, imem_rmask, iq_enqueue, iq_din
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_rdata, imem_resp, iq_full,
    input  imem_addr, imem_rmask, iq_enqueue, iq_din
  );
endinterface

// File: rtl/fetch_stage.sv
// Front-end fetch: one outstanding imem read at a time, pairs each returned
// word with its PC and pushes it into the instruction queue.
module fetch_stage #(
  parameter int unsigned            XLEN     = 32,
  parameter logic [XLEN-1:0]        RESET_PC = XLEN'(32'h1eceb000)
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  localparam int unsigned PW = 2 * XLEN;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t            state_q;
  logic [XLEN-1:0]   pc_q;
  logic              discard_q;
  logic [PW-1:0]     hold_q;

  logic [XLEN-1:0]   redir_pc;
  logic [XLEN-1:0]   pc_inc;
  logic              req_c;
  logic              enq_resp_c;
  logic              enq_hold_c;

  assign redir_pc = bus.redirect_pc & ~XLEN'(3);
  assign pc_inc   = pc_q + XLEN'(4);

  // State, PC, discard flag and hold register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      case (state_q)
        S_REQ: begin
          if (bus.redirect_valid) pc_q    <= redir_pc;
          else                    state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.redirect_valid) begin
            pc_q <= redir_pc;
            if (bus.imem_resp) begin
              state_q   <= S_REQ;
              discard_q <= 1'b0;
            end else begin
              discard_q <= 1'b1;
            end
          end else if (bus.imem_resp) begin
            if (discard_q) begin
              discard_q <= 1'b0;
              state_q   <= S_REQ;
            end else if (!bus.iq_full) begin
              pc_q    <= pc_inc;
              state_q <= S_REQ;
            end else begin
              hold_q  <= {pc_q, bus.imem_rdata};
              state_q <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (bus.redirect_valid) begin
            pc_q    <= redir_pc;
            state_q <= S_REQ;
          end else if (!bus.iq_full) begin
            pc_q    <= pc_inc;
            state_q <= S_REQ;
          end
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

  // Request and enqueue strobes; redirect suppresses both, reset forces idle
  always_comb begin
    req_c      = 1'b0;
    enq_resp_c = 1'b0;
    enq_hold_c = 1'b0;
    if (rst_n && !bus.redirect_valid) begin
      case (state_q)
        S_REQ:   req_c      = 1'b1;
        S_WAIT:  enq_resp_c = bus.imem_resp && !discard_q && !bus.iq_full;
        S_HOLD:  enq_hold_c = !bus.iq_full;
        default: req_c      = 1'b0;
      endcase
    end
  end

  assign bus.imem_rmask = req_c ? 4'hf : 4'h0;
  assign bus.imem_addr  = req_c ? pc_q : '0;
  assign bus.iq_enqueue = enq_resp_c | enq_hold_c;
  assign bus.iq_din     = enq_hold_c ? hold_q :
                          enq_resp_c ? {pc_q, bus.imem_rdata} : '0;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed plus randomized bench for fetch_stage against a transaction-level
// model of outstanding request, held pair and next fetch PC.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h1eceb000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_stage_if #(.XLEN(32)) bus ();

  fetch_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: what fetch owes the memory and the queue
  bit          m_out;
  bit          m_cancel;
  bit          m_held;
  logic [31:0] m_out_addr;
  logic [31:0] m_pc;
  logic [63:0] m_held_pair;
  logic [31:0] mem_data;
  int          mem_cnt;
  int          mem_lat = 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_out    = 1'b0;
    m_cancel = 1'b0;
    m_held   = 1'b0;
    m_pc     = RST_PC;
    mem_cnt  = 0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.iq_full        = 1'b0;
    bus.imem_resp      = 1'b0;
    bus.imem_rdata     = '0;
  endtask

  // One clock: drive inputs, check outputs at negedge, advance model at posedge
  task automatic cyc(input bit rv, input logic [31:0] rpc, input bit full);
    bit          resp_now;
    bit          exp_req;
    bit          exp_enq;
    bit          was_held;
    logic [63:0] exp_din;
    resp_now = m_out && (mem_cnt == 0);
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.iq_full        = full;
    bus.imem_resp      = resp_now;
    bus.imem_rdata     = resp_now ? mem_data : $urandom;
    @(negedge clk);
    exp_req = !m_out && !m_held && !rv;
    exp_enq = 1'b0;
    exp_din = '0;
    if (!rv && !full) begin
      if (m_held) begin
        exp_enq = 1'b1;
        exp_din = m_held_pair;
      end else if (resp_now && !m_cancel) begin
        exp_enq = 1'b1;
        exp_din = {m_out_addr, mem_data};
      end
    end
    chk("imem_rmask", 64'(bus.imem_rmask), exp_req ? 64'hf : 64'h0);
    if (exp_req) chk("imem_addr", 64'(bus.imem_addr), 64'(m_pc));
    chk("iq_enqueue", 64'(bus.iq_enqueue), 64'(exp_enq));
    if (exp_enq) chk("iq_din", bus.iq_din, exp_din);
    @(posedge clk);
    was_held = m_held;
    if (m_out && !resp_now) mem_cnt--;
    if (rv) begin
      m_pc   = rpc & ~32'h3;
      m_held = 1'b0;
      if (resp_now) begin
        m_out    = 1'b0;
        m_cancel = 1'b0;
      end else if (m_out) begin
        m_cancel = 1'b1;
      end
    end else if (exp_req) begin
      m_out      = 1'b1;
      m_out_addr = m_pc;
      m_cancel   = 1'b0;
      mem_cnt    = mem_lat - 1;
      mem_data   = $urandom;
    end else if (resp_now) begin
      m_out = 1'b0;
      if (m_cancel)   m_cancel = 1'b0;
      else if (!full) m_pc = m_pc + 32'd4;
      else begin
        m_held      = 1'b1;
        m_held_pair = {m_out_addr, mem_data};
      end
    end else if (was_held && !full) begin
      m_held = 1'b0;
      m_pc   = m_pc + 32'd4;
    end
    #1;
  endtask

  initial begin
    bit          rv;
    bit          full;
    logic [31:0] rpc;

    rst_n = 1'b0;
    model_reset();
    #12;
    chk("reset_rmask", 64'(bus.imem_rmask), 64'h0);
    chk("reset_enqueue", 64'(bus.iq_enqueue), 64'h0);
    chk("reset_din", bus.iq_din, 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Streaming with a 1-cycle memory, then a 5-cycle full stall on 1eceb004
    mem_lat = 1;
    cyc(0, '0, 0);
    cyc(0, '0, 0);
    cyc(0, '0, 0);
    cyc(0, '0, 1);
    repeat (4) cyc(0, '0, 1);
    cyc(0, '0, 0);

    // Redirect while waiting on a slow response for 1eceb008
    mem_lat = 3;
    cyc(0, '0, 0);
    cyc(1, 32'h1eceb100, 0);
    cyc(0, '0, 0);
    cyc(0, '0, 0);

    // Redirect coinciding with a response
    mem_lat = 1;
    cyc(0, '0, 0);
    cyc(1, 32'h1eceb200, 0);

    // Redirect in HOLD on the cycle full drops
    cyc(0, '0, 0);
    cyc(0, '0, 1);
    cyc(0, '0, 1);
    cyc(1, 32'h1eceb300, 0);
    cyc(0, '0, 0);
    cyc(0, '0, 0);

    // PC wrap past the top of the address space
    cyc(1, 32'hfffffffc, 0);
    cyc(0, '0, 0);
    cyc(0, '0, 0);
    mem_lat = 2;
    cyc(0, '0, 0);

    // Reset pulse mid-WAIT
    #2;
    rst_n = 1'b0;
    #1;
    chk("midwait_rmask", 64'(bus.imem_rmask), 64'h0);
    chk("midwait_enqueue", 64'(bus.iq_enqueue), 64'h0);
    chk("midwait_din", bus.iq_din, 64'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_lat = 1;
    cyc(0, '0, 0);
    cyc(0, '0, 0);
    cyc(0, '0, 0);

    // Randomized traffic: latency, backpressure, unaligned redirects, wrap region
    repeat (600) begin
      mem_lat = $urandom_range(1, 4);
      rv      = ($urandom_range(0, 7) == 0);
      full    = ($urandom_range(0, 2) == 0);
      rpc     = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hfffffff0 | (rpc & 32'hf);
      cyc(rv, rpc, full);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
